// File: rtl/rst_seq_gen_pkg.sv
// Shared FPGA reset-path definitions: sequencer state encoding and default timing.
package rst_seq_gen_pkg;

  // Defaults exceed the deepest downstream synchronizer chain at the slowest clock ratio.
  localparam int unsigned RST_ASSERT_CYCLES  = 16;
  localparam int unsigned RST_STAGGER_CYCLES = 4;

  localparam logic [1:0] RST_ST_ASSERT  = 2'd0;
  localparam logic [1:0] RST_ST_RELEASE = 2'd1;
  localparam logic [1:0] RST_ST_IDLE    = 2'd2;

  typedef enum logic [1:0] {
    ST_ASSERT  = RST_ST_ASSERT,
    ST_RELEASE = RST_ST_RELEASE,
    ST_IDLE    = RST_ST_IDLE
  } rst_state_e;

endpackage

// File: rtl/rst_seq_cnt.sv
// Up-counter with synchronous clear and terminal-count compare; shared by assert and stagger phases.
module rst_seq_cnt #(
  parameter int unsigned W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         hit_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/rst_seq_gen.sv
// Staged reset source: holds all outputs asserted, then releases them in index order with a stagger.
module rst_seq_gen
  import rst_seq_gen_pkg::*;
#(
  parameter int unsigned NUM_OUT        = 3,
  parameter int unsigned ASSERT_CYCLES  = RST_ASSERT_CYCLES,
  parameter int unsigned STAGGER_CYCLES = RST_STAGGER_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req,
  output logic [NUM_OUT-1:0] rst_out,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W = $clog2(ASSERT_CYCLES + (NUM_OUT - 1) * STAGGER_CYCLES + 1);
  localparam int unsigned IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  rst_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_OUT-1:0] rst_out_q, rst_out_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               cnt_clr;
  logic               cnt_en;
  logic               cnt_hit;
  logic [CNT_W-1:0]   cnt_term;

  assign cnt_term = (state_q == ST_ASSERT) ? CNT_W'(ASSERT_CYCLES - 1)
                                           : CNT_W'(STAGGER_CYCLES - 1);

  rst_seq_cnt #(
    .W (CNT_W)
  ) u_cnt (
    .clk_i  (clk),
    .rst_i  (reset),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .term_i (cnt_term),
    .hit_o  (cnt_hit)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    // req outranks any release or done that would occur on the same edge
    if (req) begin
      state_d   = ST_ASSERT;
      idx_d     = '0;
      rst_out_d = '1;
      busy_d    = 1'b1;
      cnt_clr   = 1'b1;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_hit) begin
            rst_out_d[0] = 1'b0;
            cnt_clr      = 1'b1;
            if (NUM_OUT == 1) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_hit) begin
            rst_out_d = rst_out_q & ~(NUM_OUT'(1) << idx_q);
            cnt_clr   = 1'b1;
            if (idx_q == IDX_W'(NUM_OUT - 1)) begin
              state_d = ST_IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ASSERT;
      idx_q     <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rst_out = rst_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Directed and randomized checks of rst_seq_gen: default 3-output instance and a 1-output, 2-cycle instance.
module tb_rst_seq_gen;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic [2:0] rst_out;
  logic       busy;
  logic       done;

  logic       reset1 = 1'b1;
  logic       req1 = 1'b0;
  logic [0:0] rst_out1;
  logic       busy1;
  logic       done1;

  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 clk = ~clk;

  rst_seq_gen u_dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .rst_out (rst_out),
    .busy    (busy),
    .done    (done)
  );

  rst_seq_gen #(
    .NUM_OUT        (1),
    .ASSERT_CYCLES  (2),
    .STAGGER_CYCLES (1)
  ) u_one (
    .clk     (clk),
    .reset   (reset1),
    .req     (req1),
    .rst_out (rst_out1),
    .busy    (busy1),
    .done    (done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Default timing: release edges 16/20/24 after the last restart, done visible after edge 24.
  function automatic logic [2:0] exp_out(input int rel);
    if (rel < 16)      return 3'b111;
    else if (rel < 20) return 3'b110;
    else if (rel < 24) return 3'b100;
    else               return 3'b000;
  endfunction

  // Restart reference is the reset-deassert point (edge 0) or the latest edge sampling req high.
  task automatic run_seq(input string tag, input int req_lo, input int req_hi, input int n_edges);
    int last;
    last = 0;
    for (int e = 1; e <= n_edges; e++) begin
      req = (e >= req_lo) && (e <= req_hi);
      tick();
      if (req) last = e;
      check({tag, "_rst_out"}, 32'(rst_out), 32'(exp_out(e - last)));
      check({tag, "_done"}, 32'(done), 32'((e - last) == 24));
      check({tag, "_busy"}, 32'(busy), 32'((e - last) < 24));
    end
    req = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic run_one(input string tag, input int req_edge);
    int last;
    last = 0;
    reset1 = 1'b1;
    tick();
    reset1 = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      req1 = (e == req_edge);
      tick();
      if (req1) last = e;
      check({tag, "_rst_out"}, 32'(rst_out1), 32'((e - last) < 2));
      check({tag, "_done"}, 32'(done1), 32'((e - last) == 2));
    end
    req1 = 1'b0;
  endtask

  initial begin
    logic [2:0] prev_out;
    int unsigned ones_run;
    int unsigned done_cnt;
    int unsigned zero_entries;
    logic valid;

    for (int i = 0; i < 5; i++) tick();
    check("reset_rst_out", 32'(rst_out), 32'h7);
    check("reset_busy", 32'(busy), 32'h1);
    check("reset_done", 32'(done), 32'h0);
    check("reset_one_rst_out", 32'(rst_out1), 32'h1);
    reset = 1'b0;

    run_seq("poweron", 0, -1, 26);

    pulse_reset();
    run_seq("req_assert", 8, 17, 42);

    pulse_reset();
    run_seq("req_release", 22, 22, 48);

    #3;
    reset = 1'b1;
    #1;
    check("async_rst_out", 32'(rst_out), 32'h7);
    check("async_busy", 32'(busy), 32'h1);
    check("async_done", 32'(done), 32'h0);
    tick();
    reset = 1'b0;
    run_seq("post_async", 0, -1, 25);

    run_one("one_plain", 0);
    run_one("one_req", 2);

    prev_out = rst_out;
    ones_run = 0;
    done_cnt = 0;
    zero_entries = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      check("st_busy", 32'(busy), 32'(|rst_out));
      check("st_one_busy", 32'(busy1), 32'(|rst_out1));
      valid = (rst_out == 3'b111) || (rst_out == 3'b110) ||
              (rst_out == 3'b100) || (rst_out == 3'b000);
      check("st_order", 32'(valid), 32'h1);
      if (prev_out == 3'b111 && rst_out != 3'b111)
        check("st_assert_width", 32'(ones_run >= 16), 32'h1);
      check("st_done_on_entry", 32'(done), 32'(prev_out != 3'b000 && rst_out == 3'b000));
      if (done) done_cnt++;
      if (prev_out != 3'b000 && rst_out == 3'b000) zero_entries++;
      ones_run = (rst_out == 3'b111) ? ones_run + 1 : 0;
      prev_out = rst_out;
      req    = ($urandom_range(0, 39) == 0);
      req1   = ($urandom_range(0, 4) == 0);
      reset  = ($urandom_range(0, 599) == 0);
      reset1 = ($urandom_range(0, 99) == 0);
    end
    check("st_done_count", done_cnt, zero_entries);
    check("st_seq_completed", 32'(zero_entries > 0), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
